// File: rtl/cla32_pipe.sv
// cla32_pipe: two-stage pipelined 32-bit carry-lookahead adder/subtractor.
// Stage 1 conditions the operands, forms per-bit propagate/generate and
// reduces them to per-nibble group propagate/generate through eight 4-bit
// lookahead units. Stage 2 resolves the group carries with a second
// lookahead level, expands them to bit carries and registers sum and flags.
// A valid/ready handshake on both sides lets the consumer stall the pipe.

module cla32_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Eight nibble groups; the second lookahead level is two 4-group units,
    // so the structure below is built for WIDTH = 32.
    localparam int NG = WIDTH / 4;

    // 4-bit lookahead unit, group outputs: {group propagate, group generate}
    function automatic logic [1:0] pg4_group(input logic [3:0] p, input logic [3:0] g);
        logic pg;
        logic gg;
        pg = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {pg, gg};
    endfunction

    // 4-bit lookahead unit, carry outputs: c[0] is the carry-in, c[3:1] the
    // carries into positions 1..3, all computed directly from p/g and cin.
    function automatic logic [3:0] pg4_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic out_valid_reg;
    logic adv_out;
    logic adv_s1;

    assign adv_out  = !out_valid_reg || out_ready;
    assign adv_s1   = !s1_valid_reg || adv_out;
    assign in_ready = adv_s1;

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning and first lookahead level
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bb;
    logic             c0_next;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] g_next;
    logic [NG-1:0]    grp_p_next;
    logic [NG-1:0]    grp_g_next;

    // Subtraction is A + ~B + 1; the add carry-in is ignored in that case.
    assign bb      = sub ? ~b : b;
    assign c0_next = sub ? 1'b1 : cin;
    assign p_next  = a ^ bb;
    assign g_next  = a & bb;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_s1_groups
            assign {grp_p_next[gi], grp_g_next[gi]} =
                pg4_group(p_next[4*gi +: 4], g_next[4*gi +: 4]);
        end
    endgenerate

    logic [WIDTH-1:0] s1_p_reg;
    logic [WIDTH-1:0] s1_g_reg;
    logic [NG-1:0]    s1_grp_p_reg;
    logic [NG-1:0]    s1_grp_g_reg;
    logic             s1_c0_reg;

    // ------------------------------------------------------------------
    // Stage 2: second lookahead level, bit carries, sum and flags
    // ------------------------------------------------------------------
    logic       pg_lo;
    logic       gg_lo;
    logic       pg_hi;
    logic       gg_hi;
    logic [3:0] c_lo;
    logic [3:0] c_hi;
    logic       c4;
    logic       c32;
    logic [NG-1:0]    grp_c;
    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;
    logic             zero_next;

    assign {pg_lo, gg_lo} = pg4_group(s1_grp_p_reg[3:0], s1_grp_g_reg[3:0]);
    assign {pg_hi, gg_hi} = pg4_group(s1_grp_p_reg[7:4], s1_grp_g_reg[7:4]);
    assign c_lo = pg4_carry(s1_grp_p_reg[3:0], s1_grp_g_reg[3:0], s1_c0_reg);
    assign c4   = gg_lo | (pg_lo & s1_c0_reg);
    assign c_hi = pg4_carry(s1_grp_p_reg[7:4], s1_grp_g_reg[7:4], c4);
    assign c32  = gg_hi | (pg_hi & c4);

    // Group carry-ins: C0..C3 from the lower unit, C4..C7 from the upper one.
    assign grp_c = {c_hi, c_lo};

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_s2_bits
            assign bit_c[4*gi +: 4] =
                pg4_carry(s1_p_reg[4*gi +: 4], s1_g_reg[4*gi +: 4], grp_c[gi]);
        end
    endgenerate

    assign sum_next  = s1_p_reg ^ bit_c;
    assign ovf_next  = bit_c[WIDTH-1] ^ c32;
    assign zero_next = (sum_next == '0);

    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // Stage 1 register: advances whenever stage 1 is empty or draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_p_reg     <= '0;
            s1_g_reg     <= '0;
            s1_grp_p_reg <= '0;
            s1_grp_g_reg <= '0;
            s1_c0_reg    <= 1'b0;
        end else if (adv_s1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_p_reg     <= p_next;
                s1_g_reg     <= g_next;
                s1_grp_p_reg <= grp_p_next;
                s1_grp_g_reg <= grp_g_next;
                s1_c0_reg    <= c0_next;
            end
        end
    end

    // Output register: holds while the consumer stalls, loads only real data.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (adv_out) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum_reg  <= sum_next;
                cout_reg <= c32;
                ovf_reg  <= ovf_next;
                zero_reg <= zero_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_cla32_pipe.sv
// Testbench for cla32_pipe: directed vectors, back-pressure, mid-flight
// reset and a long randomized run against an arithmetic reference model.

module tb_cla32_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    // Expected results in acceptance order, packed {cout, ovf, zero, sum}.
    logic [34:0] exp_q[$];

    cla32_pipe #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .sub(sub),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf),
        .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: plain 33-bit addition of A and the conditioned B.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic msub, input logic mcin);
        logic [31:0] bbv;
        logic [32:0] t;
        logic        ov;
        bbv = msub ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bbv} + {32'd0, (msub ? 1'b1 : mcin)};
        ov  = (ma[31] == bbv[31]) && (t[31] != ma[31]);
        return {t[32], ov, (t[31:0] == 32'd0), t[31:0]};
    endfunction

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b z=%b expected all zero",
                     out_valid, sum, cout, ovf, zero);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        $display("reset: out_valid=%b sum=%h in_ready=%b", out_valid, sum, in_ready);
    endtask

    task automatic test_directed;
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic        ts [5];
        logic        tc [5];
        logic [34:0] te [5];
        ta[0] = 32'h0000_FFFF; tb[0] = 32'd1; ts[0] = 0; tc[0] = 0; te[0] = {1'b0, 1'b0, 1'b0, 32'h0001_0000};
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd0; ts[1] = 0; tc[1] = 1; te[1] = {1'b1, 1'b0, 1'b1, 32'h0000_0000};
        ta[2] = 32'h7FFF_FFFF; tb[2] = 32'd1; ts[2] = 0; tc[2] = 0; te[2] = {1'b0, 1'b1, 1'b0, 32'h8000_0000};
        ta[3] = 32'd5;         tb[3] = 32'd7; ts[3] = 1; tc[3] = 1; te[3] = {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE};
        ta[4] = 32'h8000_0000; tb[4] = 32'd1; ts[4] = 1; tc[4] = 0; te[4] = {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a = ta[k]; b = tb[k]; sub = ts[k]; cin = tc[k];
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed%0d_in_ready: got %b expected 1", k, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_early_valid: got %b expected 0 after 1 cycle", k, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {cout, ovf, zero, sum} !== te[k]) begin
                errors++;
                $display("FAIL directed%0d_result: got v=%b c=%b o=%b z=%b sum=%h expected v=1 c=%b o=%b z=%b sum=%h",
                         k, out_valid, cout, ovf, zero, sum, te[k][34], te[k][33], te[k][32], te[k][31:0]);
            end
            $display("directed%0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b zero=%b",
                     k, ta[k], tb[k], ts[k], tc[k], sum, cout, ovf, zero);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic        vc [4];
        int nacc = 0;
        int nres = 0;
        logic [34:0] e;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            va[k] = $urandom; vb[k] = $urandom; vs[k] = 1'($urandom_range(1)); vc[k] = 1'($urandom_range(1));
        end
        out_ready = 1'b0;
        a = va[0]; b = vb[0]; sub = vs[0]; cin = vc[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, cin));
                nacc++;
            end
            if (cyc >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || {cout, ovf, zero, sum} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_hold cyc%0d: got v=%b sum=%h expected v=1 sum=%h",
                             cyc, out_valid, sum, exp_q[0][31:0]);
                end
            end
            @(posedge clk); #1;
            if (nacc < 4) begin
                a = va[nacc]; b = vb[nacc]; sub = vs[nacc]; cin = vc[nacc]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (nacc != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got accepts=%0d in_ready=%b expected accepts=2 in_ready=0", nacc, in_ready);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nres < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({cout, ovf, zero, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got c=%b o=%b z=%b sum=%h expected c=%b o=%b z=%b sum=%h",
                             nres, cout, ovf, zero, sum, e[34], e[33], e[32], e[31:0]);
                end
                $display("b2b result%0d: sum=%h cout=%b ovf=%b zero=%b", nres, sum, cout, ovf, zero);
                nres++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, cin));
                nacc++;
            end
            @(posedge clk); #1;
            if (nacc < 4) begin
                a = va[nacc]; b = vb[nacc]; sub = vs[nacc]; cin = vc[nacc]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (out_valid) nres++;
        end
        checks++;
        if (nres != 4 || nacc != 4) begin
            errors++;
            $display("FAIL b2b_count: got results=%0d accepts=%0d expected 4 and 4", nres, nacc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        exp_q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(1)); cin = 1'b1; in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_accept%0d: got in_ready=%b expected 1", k, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0 ||
            zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: got v=%b sum=%h c=%b o=%b z=%b rdy=%b expected 0,0,0,0,0,1",
                     out_valid, sum, cout, ovf, zero, in_ready);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_ghost: got %0d results after reset expected 0", seen);
        end
        $display("reset mid-op: discarded ops, results seen after reset=%0d", seen);
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int nacc = 0;
        int nres = 0;
        logic acc;
        logic stalled = 1'b0;
        logic [34:0] held = '0;
        logic [34:0] e;
        exp_q.delete();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 14000 && nacc < 10000; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {cout, ovf, zero, sum} !== held) begin
                    errors++;
                    $display("FAIL rand_hold cyc%0d: got v=%b sum=%h expected v=1 sum=%h",
                             cyc, out_valid, sum, held[31:0]);
                end
            end
            stalled = out_valid && !out_ready;
            held    = {cout, ovf, zero, sum};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got result sum=%h expected none pending", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, ovf, zero, sum} !== e) begin
                        errors++;
                        $display("FAIL rand_result%0d: got c=%b o=%b z=%b sum=%h expected c=%b o=%b z=%b sum=%h",
                                 nres, cout, ovf, zero, sum, e[34], e[33], e[32], e[31:0]);
                    end
                end
                nres++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(a, b, sub, cin));
                nacc++;
            end
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                a   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b   = ($urandom_range(7) == 0) ? a : $urandom;
                sub = 1'($urandom_range(1));
                cin = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got result sum=%h expected none pending", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, ovf, zero, sum} !== e) begin
                        errors++;
                        $display("FAIL rand_drain%0d: got sum=%h expected sum=%h", nres, sum, e[31:0]);
                    end
                end
                nres++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (nres != nacc || nacc == 0) begin
            errors++;
            $display("FAIL rand_count: got results=%0d expected accepts=%0d", nres, nacc);
        end
        $display("random: accepts=%0d results=%0d", nacc, nres);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
